muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide engine for the HI/LO path of the MIPS datapath.
- Driven by the decoder's start, sign and annul controls, plus a mult/div mode select.
- Raises a pipeline stall while an operation is in flight.
- Delivers {HI, LO} with a one-cycle done pulse; this replaces fixed-width, fixed-latency handling with configurable WIDTH and multiply latency.

---
 rtl/muldiv_unit.sv | 145 ++++++++++++++
 tb/tb_muldiv_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide engine: MUL_LAT-cycle multiply, restoring radix-2 divide.
// Signed operands are reduced to magnitudes at issue; sign fix-up happens when entering DONE.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             op_div,
  input  logic             sign,
  input  logic             annul,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  typedef struct packed {
    logic neg_a;
    logic neg_b;
  } op_t;

  state_t             state;
  op_t                op;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;

  logic               in_neg_a, in_neg_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod, prod_res;
  logic [WIDTH:0]     part, diff;
  logic [WIDTH-1:0]   q_nxt, r_nxt, quo_res, rem_res;

  always_comb begin
    in_neg_a = sign & src_a[WIDTH-1];
    in_neg_b = sign & src_b[WIDTH-1];
    abs_a    = in_neg_a ? -src_a : src_a;
    abs_b    = in_neg_b ? -src_b : src_b;

    prod     = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
    prod_res = (op.neg_a ^ op.neg_b) ? -prod : prod;

    // Trial subtract; bit WIDTH of diff set means the divisor did not fit.
    part     = {rem, quo[WIDTH-1]};
    diff     = part - {1'b0, mag_b};
    q_nxt    = {quo[WIDTH-2:0], ~diff[WIDTH]};
    r_nxt    = diff[WIDTH] ? part[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_res  = (op.neg_a ^ op.neg_b) ? -q_nxt : q_nxt;
    rem_res  = op.neg_a ? -r_nxt : r_nxt;
  end

  assign stall = (state == IDLE && start && !annul) || busy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      op          <= '0;
      mag_a       <= '0;
      mag_b       <= '0;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !annul) begin
            op    <= '{neg_a: in_neg_a, neg_b: in_neg_b};
            mag_a <= abs_a;
            mag_b <= abs_b;
            cnt   <= '0;
            if (op_div && src_b == '0) begin
              // Zero divisor: no iteration, report the raw dividend.
              state       <= DONE;
              hi          <= src_a;
              lo          <= '1;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
            end else if (op_div) begin
              state <= DIV;
              busy  <= 1'b1;
              rem   <= '0;
              quo   <= abs_a;
            end else begin
              state <= MUL;
              busy  <= 1'b1;
            end
          end
        end
        MUL: begin
          if (annul) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == MUL_LAST) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            {hi, lo} <= prod_res;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          if (annul) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            rem <= r_nxt;
            quo <= q_nxt;
            if (cnt == DIV_LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              hi    <= rem_res;
              lo    <= quo_res;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected {hi,lo}, flag and done cycle queued at issue.
module tb_muldiv_unit;
  localparam int W  = 32;
  localparam int ML = 2;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0, op_div = 1'b0, sign = 1'b0, annul = 1'b0;
  logic [W-1:0] src_a = '0, src_b = '0;
  logic         stall, busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op_div(op_div), .sign(sign),
    .annul(annul), .src_a(src_a), .src_b(src_b), .stall(stall), .busy(busy),
    .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
    int           cyc;
    string        tag;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0, errors = 0;
  logic [W-1:0] last_hi = '0, last_lo = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic d, input logic s,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t                r;
    logic [2*W-1:0]      ea, eb, p;
    logic signed [2*W-1:0] qa, qb, q, rm;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    r.dbz = 1'b0;
    if (!d) begin
      p    = ea * eb;
      r.hi = p[2*W-1:W];
      r.lo = p[W-1:0];
      r.lat = ML + 1;
    end else if (b == '0) begin
      r.hi  = a;
      r.lo  = '1;
      r.dbz = 1'b1;
      r.lat = 1;
    end else begin
      qa = $signed(ea);
      qb = $signed(eb);
      q  = qa / qb;
      rm = qa % qb;
      r.hi = rm[W-1:0];
      r.lo = q[W-1:0];
      r.lat = W + 1;
    end
    return r;
  endfunction

  // Called just after a rising edge; returns one cycle later with start dropped.
  task automatic issue(input string tag, input logic d, input logic s,
                       input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    exp_t e;
    e     = model(d, s, a, b);
    e.cyc = cyc + e.lat;
    e.tag = tag;
    if (push) sb.push_back(e);
    start = 1'b1; op_div = d; sign = s; src_a = a; src_b = b;
    #1 chk({tag, "_stall_t0"}, stall, 1);
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_stall_t1"}, stall, (e.lat > 1));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (resetn && done) begin
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk({e.tag, "_hi"}, hi, e.hi);
        chk({e.tag, "_lo"}, lo, e.lo);
        chk({e.tag, "_dbz"}, div_by_zero, e.dbz);
        chk({e.tag, "_lat"}, cyc, e.cyc);
        chk({e.tag, "_stall_done"}, stall, 0);
        chk({e.tag, "_busy_done"}, busy, 0);
        last_hi = e.hi;
        last_lo = e.lo;
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_hi"}, hi, 0);
    chk({tag, "_lo"}, lo, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_dbz"}, div_by_zero, 0);
    chk({tag, "_stall"}, stall, 0);
  endtask

  initial begin
    #12 chk_zero("reset");
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;

    issue("smul", 1'b0, 1'b1, 32'hFFFFFFFE, 32'd3, 1'b1); wait_done(50);
    issue("umul", 1'b0, 1'b0, 32'hFFFFFFFE, 32'd3, 1'b1); wait_done(50);
    issue("sdiv", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 1'b1); wait_done(50);
    issue("udz",  1'b1, 1'b0, 32'd7,        32'd0, 1'b1); wait_done(50);
    issue("wrap", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1); wait_done(50);
    issue("udiv", 1'b1, 1'b0, 32'hFFFFFFF9, 32'd10, 1'b1); wait_done(50);
    issue("nn",   1'b0, 1'b1, 32'h80000000, 32'h80000000, 1'b1); wait_done(50);
    issue("sdz",  1'b1, 1'b1, 32'hFFFFFF00, 32'd0, 1'b1); wait_done(50);
    issue("sdr",  1'b1, 1'b1, 32'd100,      32'hFFFFFFF9, 1'b1); wait_done(50);

    for (int i = 0; i < 8; i++) begin
      issue("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
            ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom() >> $urandom_range(0, 31), 1'b1);
      wait_done(50);
    end

    // start with annul in IDLE must be dropped; a done here would be spurious
    start = 1'b1; annul = 1'b1; op_div = 1'b0; src_a = 32'd5; src_b = 32'd5;
    #1 chk("idle_annul_stall", stall, 0);
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    chk("idle_annul_busy", busy, 0);
    repeat (4) @(posedge clk); #1;

    // start while busy is ignored: the queued result must be the only done
    issue("ign", 1'b0, 1'b0, 32'd1234, 32'd5678, 1'b1);
    start = 1'b1; op_div = 1'b1; src_b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(50);

    // annul mid-divide at T+10
    issue("ann", 1'b1, 1'b0, 32'd99999, 32'd7, 1'b0);
    repeat (9) @(posedge clk); #1;
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    chk("ann_busy", busy, 0);
    chk("ann_stall", stall, 0);
    chk("ann_hi_hold", hi, last_hi);
    chk("ann_lo_hold", lo, last_lo);
    @(posedge clk); #1;
    issue("post_ann", 1'b0, 1'b1, 32'hFFFFFFF0, 32'd16, 1'b1); wait_done(50);

    // reset mid-divide at T+10
    issue("rst", 1'b1, 1'b1, 32'hFFFF0000, 32'd3, 1'b0);
    repeat (9) @(posedge clk); #1;
    resetn = 1'b0;
    #2 chk_zero("rst_mid");
    @(posedge clk); #1 resetn = 1'b1;
    repeat (40) @(posedge clk); #1;
    chk("rst_no_done_busy", busy, 0);
    issue("post_rst", 1'b1, 1'b0, 32'd1000, 32'd33, 1'b1); wait_done(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
